// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's two handshakes: the valid/allowin link to ID
// and the single-outstanding request/response link to instruction memory.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_if;
    // IF -> ID handover
    logic        id_allowin_in;
    logic [31:0] id_nextPC_in;
    logic        if_valid_out;
    logic [31:0] if_PC_out;
    logic [31:0] if_NPC_out;
    logic [31:0] if_NNPC_out;
    logic [31:0] if_Instruct_out;
    logic [31:0] if_NPC_fast_out;
    // IF -> instruction memory
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        input  id_allowin_in, id_nextPC_in,
        output if_valid_out, if_PC_out, if_NPC_out, if_NNPC_out,
        output if_Instruct_out, if_NPC_fast_out,
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        output id_allowin_in, id_nextPC_in,
        input  if_valid_out, if_PC_out, if_NPC_out, if_NNPC_out,
        input  if_Instruct_out, if_NPC_fast_out,
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Holds the fetch PC, issues exactly one memory
// request at a time, buffers the returned word and hands {PC, NPC, NNPC,
// instruction} to ID. The PC only moves on a completed IF->ID handshake,
// where ID supplies the next fetch address (branch target or PC+4).
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic      clk,
    input  logic      rst,
    if_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_VALID
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_nnpc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_req;

    // ID takes the buffered instruction; only meaningful while r_valid is set,
    // so if_valid_out itself never depends on id_allowin_in.
    logic        w_handshake;
    logic [31:0] w_next_pc;

    assign w_handshake = r_valid & bus.id_allowin_in;
    assign w_next_pc   = bus.id_nextPC_in;

    // Fetch sequencer: request, wait for data, hold for ID, advance PC on handover.
    always_ff @(posedge clk) begin
        // NOTE: every register here is assigned with <= so all of them update
        // from the same pre-edge values; a blocking = would let later lines
        // see this cycle's new state and silently change the behaviour.
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC + 32'd4;
            r_nnpc  <= RESET_PC + 32'd8;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                    r_req   <= 1'b1;
                end
                ST_REQ: begin
                    // Address and request stay untouched until memory accepts.
                    if (bus.inst_addr_ok) begin
                        r_req <= 1'b0;
                        if (bus.inst_data_ok) begin
                            r_instr <= bus.inst_rdata;
                            r_valid <= 1'b1;
                            r_state <= ST_VALID;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.inst_data_ok) begin
                        r_instr <= bus.inst_rdata;
                        r_valid <= 1'b1;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // A stalled ID keeps the delay-slot instruction parked here.
                    if (w_handshake) begin
                        r_pc    <= w_next_pc;
                        r_npc   <= w_next_pc + 32'd4;
                        r_nnpc  <= w_next_pc + 32'd8;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_valid_out    = r_valid;
    assign bus.if_PC_out       = r_pc;
    assign bus.if_NPC_out      = r_npc;
    assign bus.if_NNPC_out     = r_nnpc;
    assign bus.if_Instruct_out = r_instr;
    assign bus.if_NPC_fast_out = r_pc + 32'd4;
    assign bus.inst_req        = r_req;
    assign bus.inst_addr       = r_pc;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal
// expectations, then randomized memory latency, ID stalls, branch targets,
// spurious data_ok pulses and random resets, all compared every cycle
// against a transaction-level model of the fetch stage.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    if_fetch_if bus();

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event never occurred (t=%0t)", name, $time);
    endtask

    // Contents of the instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks the fetch transaction as seen from outside --
    // which address is owed to ID, whether a request must be on the bus,
    // whether a word is in flight, and whether ID is being offered one.
    // ------------------------------------------------------------------
    logic [31:0] m_pc = RST_PC;
    bit m_live    = 0;
    bit m_idle    = 0;
    bit m_req     = 0;
    bit m_out     = 0;
    bit m_valid   = 0;
    bit m_ir_zero = 0;
    int hs_done   = 0;
    int hs_req    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live    = 1;
            m_pc      = RST_PC;
            m_idle    = 1;
            m_req     = 0;
            m_out     = 0;
            m_valid   = 0;
            m_ir_zero = 1;
        end else if (m_live) begin
            if (m_idle) begin
                m_idle = 0;
                m_req  = 1;
            end else if (m_req) begin
                if (bus.inst_addr_ok) begin
                    m_req = 0;
                    if (bus.inst_data_ok) begin
                        m_valid   = 1;
                        m_ir_zero = 0;
                    end else begin
                        m_out = 1;
                    end
                end
            end else if (m_out) begin
                if (bus.inst_data_ok) begin
                    m_out     = 0;
                    m_valid   = 1;
                    m_ir_zero = 0;
                end
            end else if (m_valid && bus.id_allowin_in) begin
                m_pc    = bus.id_nextPC_in;
                m_valid = 0;
                m_req   = 1;
                hs_done++;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_live) begin
            check("valid", 32'(bus.if_valid_out), 32'(m_valid));
            check("req", 32'(bus.inst_req), 32'(m_req));
            if (m_req) check("addr", bus.inst_addr, m_pc);
            check("pc", bus.if_PC_out, m_pc);
            check("npc", bus.if_NPC_out, m_pc + 32'd4);
            check("nnpc", bus.if_NNPC_out, m_pc + 32'd8);
            check("npc_fast", bus.if_NPC_fast_out, m_pc + 32'd4);
            if (m_valid) check("instr", bus.if_Instruct_out, mem_word(m_pc));
            else if (m_ir_zero) check("instr_rst", bus.if_Instruct_out, 32'h0);
        end
    end

    // ------------------------------------------------------------------
    // Environment drivers: instruction memory and ID, updated just after
    // each rising edge.
    // ------------------------------------------------------------------
    int          cfg_delay = 0;
    int          cfg_lat   = 0;
    bit          cfg_rand  = 0;
    bit          cfg_junk  = 0;
    int          id_mode   = 0;   // 0: scripted handshakes, 1: random ID
    logic [31:0] man_next  = 32'h0;

    initial begin
        int          addr_wait;
        int          lat;
        int          cnt;
        bit          pend;
        logic [31:0] paddr;
        logic [31:0] r;
        addr_wait = -1;
        lat       = 0;
        cnt       = 0;
        pend      = 0;
        paddr     = '0;
        bus.inst_addr_ok  = 1'b0;
        bus.inst_data_ok  = 1'b0;
        bus.inst_rdata    = '0;
        bus.id_allowin_in = 1'b0;
        bus.id_nextPC_in  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = $urandom;
            if (rst) begin
                pend      = 0;
                addr_wait = -1;
            end else if (pend) begin
                if (cnt == 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = mem_word(paddr);
                    pend             = 0;
                end else begin
                    cnt--;
                end
            end else if (bus.inst_req) begin
                if (addr_wait < 0) addr_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_delay;
                if (addr_wait == 0) begin
                    bus.inst_addr_ok = 1'b1;
                    addr_wait        = -1;
                    lat              = cfg_rand ? int'($urandom_range(0, 3)) : cfg_lat;
                    if (lat == 0) begin
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = mem_word(bus.inst_addr);
                    end else begin
                        pend  = 1;
                        cnt   = lat - 1;
                        paddr = bus.inst_addr;
                    end
                end else begin
                    addr_wait--;
                end
            end else if (cfg_junk && $urandom_range(0, 3) == 0) begin
                bus.inst_data_ok = 1'b1;
            end

            if (id_mode == 0) begin
                bus.id_allowin_in = (hs_req != hs_done);
                bus.id_nextPC_in  = man_next;
            end else begin
                bus.id_allowin_in = 1'($urandom_range(0, 1));
                r = $urandom;
                bus.id_nextPC_in = ($urandom_range(0, 1) == 1) ? m_pc + 32'd4 : {r[31:2], 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (called at a falling edge).
    // ------------------------------------------------------------------
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        for (int i = 0; i < 50 && bus.if_valid_out !== 1'b1; i++) @(negedge clk);
        if (bus.if_valid_out !== 1'b1) fail_now(name);
        else check(name, bus.if_PC_out, exp_pc);
    endtask

    task automatic watch_req(input string name, input logic [31:0] exp_addr, input int exp_cycles);
        int n;
        n = 0;
        for (int i = 0; i < 50 && bus.inst_req !== 1'b1; i++) @(negedge clk);
        if (bus.inst_req !== 1'b1) begin
            fail_now(name);
        end else begin
            while (bus.inst_req === 1'b1 && n < 50) begin
                check({name, "_addr"}, bus.inst_addr, exp_addr);
                n++;
                @(negedge clk);
            end
            check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
        end
    endtask

    initial begin
        // Reset held for two edges, zero-latency memory, ID not accepting.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t1_idle_req", 32'(bus.inst_req), 32'h0);
        check("t1_idle_valid", 32'(bus.if_valid_out), 32'h0);
        check("t1_idle_instr", bus.if_Instruct_out, 32'h0);
        @(negedge clk);
        check("t1_req", 32'(bus.inst_req), 32'h1);
        check("t1_addr", bus.inst_addr, 32'hBFC0_0000);
        @(negedge clk);
        check("t1_valid", 32'(bus.if_valid_out), 32'h1);
        check("t1_pc", bus.if_PC_out, 32'hBFC0_0000);
        check("t1_npc", bus.if_NPC_out, 32'hBFC0_0004);
        check("t1_nnpc", bus.if_NNPC_out, 32'hBFC0_0008);
        check("t1_instr", bus.if_Instruct_out, 32'hA5C3_B0DE);

        // ID stalls for five cycles: everything frozen, nothing requested.
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.if_valid_out), 32'h1);
            check("t3_hold_req", 32'(bus.inst_req), 32'h0);
            check("t3_hold_pc", bus.if_PC_out, 32'hBFC0_0000);
        end

        // Release ID; memory withholds addr_ok for three cycles.
        cfg_delay = 3;
        man_next  = 32'hBFC0_0004;
        hs_req++;
        watch_req("t2_delay", 32'hBFC0_0004, 4);
        cfg_delay = 0;
        wait_valid("t2_valid", 32'hBFC0_0004);

        // Sequential fetch of the delay slot, then ID redirects to a target.
        man_next = 32'hBFC0_0008;
        hs_req++;
        watch_req("t4_seq", 32'hBFC0_0008, 1);
        wait_valid("t4_slot", 32'hBFC0_0008);
        man_next = 32'h8000_1000;
        hs_req++;
        watch_req("t4_target", 32'h8000_1000, 1);
        wait_valid("t4_valid", 32'h8000_1000);
        check("t4_npc", bus.if_NPC_out, 32'h8000_1004);
        check("t4_nnpc", bus.if_NNPC_out, 32'h8000_1008);

        // Reset while a word is still in flight.
        cfg_lat  = 6;
        man_next = 32'h0040_0000;
        hs_req++;
        watch_req("t5_req", 32'h0040_0000, 1);
        check("t5_waiting", 32'(bus.if_valid_out), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_valid", 32'(bus.if_valid_out), 32'h0);
        check("t5_rst_req", 32'(bus.inst_req), 32'h0);
        check("t5_rst_pc", bus.if_PC_out, 32'hBFC0_0000);
        check("t5_rst_instr", bus.if_Instruct_out, 32'h0);
        cfg_lat = 0;
        watch_req("t5_refetch", 32'hBFC0_0000, 1);
        wait_valid("t5_valid", 32'hBFC0_0000);

        // PC wrap at the top of the address space.
        man_next = 32'hFFFF_FFFC;
        hs_req++;
        watch_req("t6_req", 32'hFFFF_FFFC, 1);
        wait_valid("t6_valid", 32'hFFFF_FFFC);
        check("t6_fast", bus.if_NPC_fast_out, 32'h0000_0000);
        check("t6_npc", bus.if_NPC_out, 32'h0000_0000);
        check("t6_nnpc", bus.if_NNPC_out, 32'h0000_0004);
        man_next = bus.if_NPC_fast_out;
        hs_req++;
        watch_req("t6_wrap", 32'h0000_0000, 1);
        wait_valid("t6_wrap_valid", 32'h0000_0000);
        check("t6_wrap_nnpc", bus.if_NNPC_out, 32'h0000_0008);

        // Randomized traffic with occasional resets.
        cfg_rand = 1;
        cfg_junk = 1;
        id_mode  = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst     = 1'b0;
        id_mode = 0;
        hs_req  = hs_done;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
